// File: rtl/gray_conv_sched.sv
// Two-requester round-robin scheduler sharing one Gray-to-binary converter.
// Define GRAY_FAST_EN for a single-cycle parallel conversion instead of the bit-serial one.
module gray_conv_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_gray,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_gray,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_id,
    input  logic             out_ready,
    output logic [1:0]       o_dbg_state
);

    // Handshakes: a word moves on a port in any cycle where its valid and ready are both 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_g;
    logic             r_valid;
    logic [WIDTH-1:0] r_bin;
    logic             r_id;

    logic w_grant0;
    logic w_grant1;
    logic w_accept;

    // Requester 1 wins only when requester 0 is idle or priority points at it.
    assign w_grant0 = !rst && (r_state == IDLE) && req0_valid && (!req1_valid || !r_prio);
    assign w_grant1 = !rst && (r_state == IDLE) && req1_valid && (!req0_valid || r_prio);
    assign w_accept = w_grant0 || w_grant1;

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign out_valid   = r_valid;
    assign out_bin     = r_bin;
    assign out_id      = r_id;
    assign o_dbg_state = r_state;

`ifdef GRAY_FAST_EN
    logic [WIDTH-1:0] w_fast;

    always_comb begin
        w_fast = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fast[i] = ^(r_g >> i);
        end
    end
`else
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_gbit;
    logic          w_prev;

    // Bits above the MSB shift in as zero, so the top bit needs no special case.
    assign w_gbit = |((r_g >> r_cnt) & WIDTH'(1));
    assign w_prev = |((r_bin >> r_cnt) & WIDTH'(2));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_g     <= '0;
            r_valid <= 1'b0;
            r_bin   <= '0;
            r_id    <= 1'b0;
`ifndef GRAY_FAST_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_g     <= w_grant1 ? req1_gray : req0_gray;
                        r_id    <= w_grant1;
                        r_bin   <= '0;
`ifndef GRAY_FAST_EN
                        r_cnt   <= CW'(WIDTH - 1);
`endif
                        r_state <= CONV;
                    end
                end
                CONV: begin
`ifdef GRAY_FAST_EN
                    r_bin   <= w_fast;
                    r_valid <= 1'b1;
                    r_state <= DONE;
`else
                    r_bin[r_cnt] <= w_prev ^ w_gbit;
                    if (r_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_prio  <= ~r_id;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed bench for gray_conv_sched (WIDTH=4); expected results are hand-computed.
// Outputs are also scored through an expected queue popped on each output handshake.
module tb_gray_conv_sched;

    localparam int W = 4;
`ifdef GRAY_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = W;
`endif

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_gray;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_gray;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_bin;
    logic         out_id;
    logic         out_ready;
    logic [1:0]   o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];

    gray_conv_sched #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_gray   (req0_gray),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_gray   (req1_gray),
        .req1_ready  (req1_ready),
        .out_valid   (out_valid),
        .out_bin     (out_bin),
        .out_id      (out_id),
        .out_ready   (out_ready),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard: every output handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got id=%0d bin=0x%0h expected no output", out_id, out_bin);
            end else begin
                check("sb_out", {out_id, out_bin}, exp_q.pop_front());
            end
        end
    end

    // Driver: one request from a single requester, followed through to its output handshake.
    task automatic run_one(input logic id, input logic [W-1:0] gray,
                           input logic [W-1:0] exp_bin, input string tag);
        int n;
        exp_q.push_back({id, exp_bin});
        if (id) begin
            req1_valid = 1'b1;
            req1_gray  = gray;
        end else begin
            req0_valid = 1'b1;
            req0_gray  = gray;
        end
        #1;
        check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_gray  = ~gray;
        req1_gray  = ~gray;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_bin"}, out_bin, exp_bin);
        check({tag, "_id"}, out_id, id);
        tick();
        check({tag, "_valid_clear"}, out_valid, 0);
    endtask

    initial begin
        int n;
        logic seen;
        logic stable;
        int codes[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_gray  = 4'b1010;
        req1_valid = 1'b1;
        req1_gray  = 4'b0101;
        out_ready  = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_id", out_id, 0);
        check("rst_state", o_dbg_state, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        run_one(1'b0, 4'b1000, 4'b1111, "single");

        // Contention straight after reset: requester 0 first, requester 1 waits.
        do_reset();
        exp_q.push_back({1'b0, 4'b1000});
        exp_q.push_back({1'b1, 4'b0011});
        req0_valid = 1'b1;
        req0_gray  = 4'b1100;
        req1_valid = 1'b1;
        req1_gray  = 4'b0010;
        #1;
        check("cont_req0_ready", req0_ready, 1);
        check("cont_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (req1_ready) seen = 1'b1;
            tick();
            n++;
        end
        if (req1_ready) seen = 1'b1;
        check("cont_first_latency", n, LAT);
        check("cont_first_bin", out_bin, 4'b1000);
        check("cont_first_id", out_id, 0);
        check("cont_req1_held_off", seen, 0);
        tick();
        check("cont_req1_ready_next", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("cont_second_latency", n, LAT);
        check("cont_second_bin", out_bin, 4'b0011);
        check("cont_second_id", out_id, 1);
        tick();

        // Backpressure: result must hold for 10 cycles with out_ready low.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'b0100});
        req0_valid = 1'b1;
        req0_gray  = 4'b0110;
        #1;
        check("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_latency", n, LAT);
        req1_valid = 1'b1;
        req1_gray  = 4'b1111;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_bin !== 4'b0100 || out_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        req1_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_released_valid", out_valid, 0);
        check("bp_released_state", o_dbg_state, 0);

        // Reset two cycles after acceptance discards the transaction.
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_gray  = 4'b1111;
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_state", o_dbg_state, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("midrst_valid_after", out_valid, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_gray  = 4'b0101;
        req1_gray  = 4'b0001;
        #1;
        check("midrst_prio_req0", req0_ready, 1);
        check("midrst_prio_req1", req1_ready, 0);
        req1_valid = 1'b0;
        run_one(1'b0, 4'b0101, 4'b0110, "midrst_next");

        for (int i = 0; i < 16; i++) begin
            run_one(1'b1, codes[i][W-1:0], i[W-1:0], "sweep");
        end

        run_one(1'b0, 4'b1001, 4'b1110, "g1001");

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Two-requester scheduler that shares one Gray-to-binary conversion datapath. Each requester submits a WIDTH-bit Gray code over a valid/ready handshake. A round-robin arbiter grants one request at a time. A small FSM sequences the conversion bit-serially, MSB first, and presents the binary result with the requester ID on a backpressured output port. It sits between Gray-coded sources (position encoders, async-FIFO pointers) and binary consumers that share one converter.

## Interface
- WIDTH, 4, Gray/binary word width; legal range 2..16.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a Gray word.
- req0_gray  input  WIDTH  requester 0 Gray word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a Gray word.
- req1_gray  input  WIDTH  requester 1 Gray word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- out_valid  output  1  result available.
- out_bin  output  WIDTH  binary result.
- out_id  output  1  requester that owns the result.
- out_ready  input  1  consumer accepts the result.

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- **IDLE**
  - Arbitrate among valid requesters using the round-robin pointer `prio`; reset value selects requester 0.
  - If only one requester is valid, it wins.
  - If both are valid, the requester named by `prio` wins.
  - The winner's `reqN_ready` is 1 combinationally in the same cycle. The loser's ready is 0.
  - On acceptance: latch the Gray word into `g_reg`, set `out_id` to the winner, clear `out_bin`, load bit counter `cnt` = WIDTH-1, go to CONV.
  - With no valid request, stay in IDLE.
- **CONV** (one bit per cycle)
  - At `cnt` = WIDTH-1: `out_bin[cnt]` = `g_reg[cnt]`.
  - Otherwise: `out_bin[cnt]` = `out_bin[cnt+1]` ^ `g_reg[cnt]`.
  - At `cnt` = 0: go to DONE. Otherwise decrement `cnt`.
  - Both reqN_ready are 0 in CONV and DONE.
- **DONE**
  - `out_valid` = 1.
  - `out_bin` and `out_id` are held stable until `out_valid & out_ready`.
  - On that handshake: go to IDLE and set `prio` to the other requester, i.e. `prio` = ~`out_id`.
- `prio` updates only on output handshake. A requester that wins with no contention still yields priority.
- No arithmetic beyond XOR. All widths are exactly WIDTH, with no extension.
- Inputs are sampled only at acceptance. Changes to `reqN_gray` after acceptance are ignored.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0
  - out_bin 0
  - out_id 0
  - prio 0
  - cnt 0
  - req0_ready 0 and req1_ready 0 while rst is high.
- Latency: acceptance at edge k. CONV occupies edges k+1..k+WIDTH. `out_valid` is 1 from edge k+WIDTH onward.
- Minimum issue interval: WIDTH+2 cycles per result (accept, WIDTH conversion cycles, output handshake, then the next accept from IDLE).
- Backpressure: `out_ready` low in DONE holds everything indefinitely. `out_ready` is ignored in IDLE and CONV.
- Reset mid-operation (CONV or DONE): the transaction is discarded immediately (async) with no partial output, and all state returns to reset values.
- Simultaneous req0/req1 valid with the `prio` winner's valid dropping the same cycle: arbitration uses current-cycle valids only. The other requester wins if valid.

## Configuration
- GRAY_FAST_EN defined:
  - CONV lasts exactly one cycle. All bits are computed in parallel: `out_bin[i]` = XOR of `g_reg[WIDTH-1:i]`.
  - `cnt` is unused. Latency is 1 cycle; issue interval is 3 cycles.
- GRAY_FAST_EN undefined: bit-serial behaviour as above, latency WIDTH.
- Ports, handshakes and arbitration are identical in both builds.

## Test plan
- Single request, default WIDTH=4, serial build: req0 presents gray 4'b1000 while out_ready=1 → req0_ready pulses 1 cycle; 4 cycles later out_valid=1, out_bin=4'b1111, out_id=0.
- Contention after reset: req0=4'b1100 and req1=4'b0010, both valid from the same cycle → first result out_bin=4'b1000 with out_id=0, then out_bin=4'b0011 with out_id=1; req1_ready is never high before the first output handshake.
- Backpressure: out_ready held 0 for 10 cycles in DONE → out_valid, out_bin and out_id remain constant and both readys stay 0; raising out_ready completes the transfer in that cycle.
- Reset mid-CONV: assert rst 2 cycles after acceptance → out_valid stays 0; after release the state is IDLE and prio=0; the next request converts correctly.
- Exhaustive sweep: all 16 Gray codes from requester 1 (0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8) → out_bin equals 0..15 in order, each with out_id=1.
- With GRAY_FAST_EN: gray 4'b1001 → out_valid 1 cycle after acceptance with out_bin=4'b1110.
